// File: rtl/mac_stream_driver_pkg.sv
// mac_stream_driver_pkg
// Shared definitions for the MAC stream driver and the MAC it sequences.
//   state_t : driver FSM states (IDLE, RUN, DRAIN, DONE)
//   ACC_W   : accumulator / result width
//   DATA_W  : activation and weight width
package mac_stream_driver_pkg;

    localparam int ACC_W  = 32;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bit_parallel_mac.sv
// bit_parallel_mac
// Single multiply-accumulate unit: result <= acc + x*weight on every enabled beat.
// The product is built from shifted partial products, one per weight bit, and is
// zero-extended into a 32-bit wrap-around sum. Reset is synchronous.
// With SHARED_W=1 the weight lives in a register loaded by update_w. A beat that
// also raises update_w uses the incoming weight directly, so a driver that updates
// on every beat sees plain x*weight behaviour.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   en                  beat enable
//   update_w            load the shared weight register
//   x, weight           unsigned operands
//   acc                 accumulation operand
//   result              registered accumulation result
module bit_parallel_mac
    import mac_stream_driver_pkg::*;
#(
    parameter int SHARED_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              update_w,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] weight,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  result
);

    logic [DATA_W-1:0]   weight_q;
    logic [DATA_W-1:0]   weight_eff;
    logic [2*DATA_W-1:0] product;

    // Shared weight register, refreshed whenever the initiator asks for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            weight_q <= '0;
        end else if (update_w) begin
            weight_q <= weight;
        end
    end

    // A beat that updates the weight must use that new weight immediately.
    always_comb begin
        weight_eff = (SHARED_W == 0 || update_w) ? weight : weight_q;
    end

    // Sum of shifted partial products, one per set weight bit.
    always_comb begin
        product = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (weight_eff[i]) begin
                product = product + ((2*DATA_W)'(x) << i);
            end
        end
    end

    // Accumulate on enabled beats only; otherwise the result holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else if (en) begin
            result <= acc + ACC_W'(product);
        end
    end

endmodule

// File: rtl/mac_stream_driver.sv
// mac_stream_driver
// Initiator-side sequencer for one bit_parallel_mac (SHARED_W=1). It accepts a
// dot-product job (len, bias) and issues one MAC beat per accepted (x, w) pair.
// The MAC's registered result is fed back as the next accumulation operand, and
// the final sum is returned on a ready/valid output.
// Optional build macro MAC_STREAM_DRIVER_RELU_EN: when defined, a negative final
// sum is returned as 0. MAC traffic is the same in both builds.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start, len, bias        job request (sampled only when accepted in IDLE)
//   busy                    high whenever a job is in progress
//   in_valid/in_ready       pair stream handshake
//   in_x, in_w              activation and weight bytes
//   mac_en, mac_update_w    registered beat enable (both the same)
//   mac_x, mac_weight       registered beat operands
//   mac_acc                 accumulation operand (bias on first beat, else feedback)
//   mac_result              MAC registered result
//   out_valid/out_ready     sum handshake
//   out_data                final sum
module mac_stream_driver
    import mac_stream_driver_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic              mac_en,
    output logic              mac_update_w,
    output logic [DATA_W-1:0] mac_x,
    output logic [DATA_W-1:0] mac_weight,
    output logic [ACC_W-1:0]  mac_acc,
    input  logic [ACC_W-1:0]  mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data
);

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [ACC_W-1:0]  bias_q;
    logic              first_q;
    logic              mac_en_q;
    logic [DATA_W-1:0] mac_x_q;
    logic [DATA_W-1:0] mac_weight_q;
    logic              start_accept;
    logic              pair_fire;

    assign start_accept = (state_q == IDLE) && start;
    assign pair_fire    = (state_q == RUN) && in_valid;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length job skips RUN: its single dummy beat is issued straight from
    // IDLE, so the DRAIN cycle is where that beat reaches the MAC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (in_valid && rem_q == LEN_W'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status and result outputs. out_data is only driven in DONE, where the
    // MAC is idle and its result is stable.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == RUN);
        out_valid = (state_q == DONE);
        out_data  = '0;
        if (state_q == DONE) begin
`ifdef MAC_STREAM_DRIVER_RELU_EN
            out_data = mac_result[ACC_W-1] ? '0 : mac_result;
`else
            out_data = mac_result;
`endif
        end
    end

    // Job registers and MAC beat registers. first_q marks the job's first beat,
    // which must take the bias instead of the feedback. It drops after that
    // beat, however many bubbles precede it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q        <= '0;
            bias_q       <= '0;
            first_q      <= 1'b0;
            mac_en_q     <= 1'b0;
            mac_x_q      <= '0;
            mac_weight_q <= '0;
        end else begin
            mac_en_q <= 1'b0;
            if (mac_en_q) begin
                first_q <= 1'b0;
            end
            if (start_accept) begin
                bias_q  <= bias;
                rem_q   <= len;
                first_q <= 1'b1;
                if (len == '0) begin
                    mac_en_q     <= 1'b1;
                    mac_x_q      <= '0;
                    mac_weight_q <= '0;
                end
            end
            if (pair_fire) begin
                mac_en_q     <= 1'b1;
                mac_x_q      <= in_x;
                mac_weight_q <= in_w;
                rem_q        <= rem_q - LEN_W'(1);
            end
        end
    end

    assign mac_en       = mac_en_q;
    assign mac_update_w = mac_en_q;
    assign mac_x        = mac_x_q;
    assign mac_weight   = mac_weight_q;
    assign mac_acc      = first_q ? bias_q : mac_result;

endmodule

// File: tb/tb_mac_stream_driver.sv
// tb_mac_stream_driver
// Drives mac_stream_driver against a bit_parallel_mac (SHARED_W=1). A timestamp
// model predicts every visible output from the job/pair history, and a compare
// process checks the DUT against it on every cycle. Directed jobs pin the model
// with hand-computed sums and latencies; random jobs follow.
// Honours MAC_STREAM_DRIVER_RELU_EN for the expected final sum.
module tb_mac_stream_driver;
    import mac_stream_driver_pkg::*;

    localparam int LEN_W = 8;
    localparam int INF   = 1 << 30;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              start      = 1'b0;
    logic [LEN_W-1:0]  len        = '0;
    logic [ACC_W-1:0]  bias       = '0;
    logic              busy;
    logic              in_valid   = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_x       = '0;
    logic [DATA_W-1:0] in_w       = '0;
    logic              mac_en;
    logic              mac_update_w;
    logic [DATA_W-1:0] mac_x;
    logic [DATA_W-1:0] mac_weight;
    logic [ACC_W-1:0]  mac_acc;
    logic [ACC_W-1:0]  mac_result;
    logic              out_valid;
    logic              out_ready  = 1'b0;
    logic [ACC_W-1:0]  out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_stream_driver #(.LEN_W(LEN_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .bias         (bias),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_w         (in_w),
        .mac_en       (mac_en),
        .mac_update_w (mac_update_w),
        .mac_x        (mac_x),
        .mac_weight   (mac_weight),
        .mac_acc      (mac_acc),
        .mac_result   (mac_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    bit_parallel_mac #(.SHARED_W(1)) u_mac (
        .clk      (clk),
        .reset    (reset),
        .en       (mac_en),
        .update_w (mac_update_w),
        .x        (mac_x),
        .weight   (mac_weight),
        .acc      (mac_acc),
        .result   (mac_result)
    );

    function automatic logic [31:0] prod(input logic [7:0] a, input logic [7:0] b);
        return 32'(a) * 32'(b);
    endfunction

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef MAC_STREAM_DRIVER_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=handshake at %0t", name, $time);
    endtask

    // Behavioural model: cycle index plus timestamps of when in_ready/out_valid apply.
    int          cyc          = 0;
    bit          m_active     = 1'b0;
    int          m_pairs      = 0;
    int          m_ready_from = INF;
    int          m_valid_at   = INF;
    logic [31:0] m_sum        = '0;
    bit          m_beat       = 1'b0;
    logic [7:0]  m_bx         = '0;
    logic [7:0]  m_bw         = '0;
    logic [31:0] m_bacc       = '0;
    logic [31:0] m_result     = '0;
    bit          m_known      = 1'b0;
    int          en_count     = 0;

    initial begin
        forever begin
            bit          nb;
            logic [7:0]  nx;
            logic [7:0]  nw;
            logic [31:0] nacc;
            @(posedge clk);
            nb = 1'b0; nx = '0; nw = '0; nacc = '0;
            if (reset) begin
                m_active     = 1'b0;
                m_pairs      = 0;
                m_ready_from = INF;
                m_valid_at   = INF;
                m_result     = '0;
                m_known      = 1'b1;
            end else begin
                if (m_beat) m_result = m_bacc + prod(m_bx, m_bw);
                if (!m_active) begin
                    if (start) begin
                        m_active = 1'b1;
                        m_sum    = bias;
                        m_pairs  = int'(len);
                        if (len == '0) begin
                            nb = 1'b1; nacc = bias;
                            m_ready_from = INF;
                            m_valid_at   = cyc + 2;
                        end else begin
                            m_ready_from = cyc + 1;
                            m_valid_at   = INF;
                        end
                    end
                end else begin
                    if (m_pairs > 0 && cyc >= m_ready_from && in_valid) begin
                        nb = 1'b1; nx = in_x; nw = in_w; nacc = m_sum;
                        m_sum   = m_sum + prod(in_x, in_w);
                        m_pairs = m_pairs - 1;
                        if (m_pairs == 0) m_valid_at = cyc + 2;
                    end
                    if (cyc >= m_valid_at && out_ready) m_active = 1'b0;
                end
            end
            m_beat = reset ? 1'b0 : nb;
            m_bx = nx; m_bw = nw; m_bacc = nacc;
            cyc++;
        end
    end

    // Compare process: every DUT output against the model, once per cycle.
    initial begin
        forever begin
            bit e_rdy;
            bit e_val;
            @(negedge clk);
            if (reset) begin
                checkOutput("rst_busy", 32'(busy), 32'd0);
                checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
                checkOutput("rst_mac_en", 32'(mac_en), 32'd0);
                checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
                checkOutput("rst_out_data", out_data, 32'd0);
            end else begin
                e_rdy = m_active && m_pairs > 0 && cyc >= m_ready_from;
                e_val = m_active && cyc >= m_valid_at;
                if (mac_en) en_count++;
                checkOutput("busy", 32'(busy), 32'(m_active));
                checkOutput("in_ready", 32'(in_ready), 32'(e_rdy));
                checkOutput("mac_en", 32'(mac_en), 32'(m_beat));
                checkOutput("mac_update_w", 32'(mac_update_w), 32'(m_beat));
                if (m_beat) begin
                    checkOutput("mac_x", 32'(mac_x), 32'(m_bx));
                    checkOutput("mac_weight", 32'(mac_weight), 32'(m_bw));
                    checkOutput("mac_acc", mac_acc, m_bacc);
                end
                checkOutput("out_valid", 32'(out_valid), 32'(e_val));
                if (e_val) checkOutput("out_data", out_data, relu(m_sum));
                if (m_known) checkOutput("mac_result", mac_result, m_result);
            end
        end
    end

    logic [7:0]  px [0:255];
    logic [7:0]  pw [0:255];
    int          gaps [0:255];
    logic [31:0] cap_out;
    logic [31:0] cap_model;
    int          start_cyc;
    int          hs_cyc;
    int          valid_cyc;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearGaps();
        for (int i = 0; i < 256; i++) gaps[i] = 0;
    endtask

    // Runs one job from start to the out handshake (or stops after stopAfter pairs).
    task automatic applyStimulus(input logic [31:0] b, input int n, input int readyDelay,
                                 input bit pulseStart, input int stopAfter);
        bit done;
        int guard;
        start = 1'b1; bias = b; len = LEN_W'(n); start_cyc = cyc;
        tick();
        start = 1'b0; bias = $urandom; len = LEN_W'($urandom);
        for (int i = 0; i < n; i++) begin
            if (i == stopAfter) return;
            repeat (gaps[i]) begin
                in_x = 8'($urandom); in_w = 8'($urandom);
                tick();
            end
            in_valid = 1'b1; in_x = px[i]; in_w = pw[i];
            done = 1'b0; guard = 0;
            while (!done && guard < 100) begin
                @(negedge clk);
                done = in_ready;
                if (done) hs_cyc = cyc;
                tick();
                guard++;
            end
            in_valid = 1'b0;
            if (!done) begin
                reportTimeout("pair_handshake");
                return;
            end
        end
        done = 1'b0; guard = 0;
        while (!done && guard < 100) begin
            @(negedge clk);
            if (out_valid) begin
                done = 1'b1;
                valid_cyc = cyc;
                cap_out = out_data;
                cap_model = relu(m_sum);
            end else begin
                tick();
            end
            guard++;
        end
        if (!done) begin
            reportTimeout("out_valid");
            return;
        end
        tick();
        repeat (readyDelay) begin
            start = pulseStart; len = LEN_W'($urandom); bias = $urandom;
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] t2_exp;
`ifdef MAC_STREAM_DRIVER_RELU_EN
        t2_exp = 32'd0;
`else
        t2_exp = 32'hFFFF_FFF0;
`endif
        $display("[TB] start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
        checkOutput("reset_mac_en", 32'(mac_en), 32'd0);
        checkOutput("reset_mac_update_w", 32'(mac_update_w), 32'd0);
        checkOutput("reset_mac_x", 32'(mac_x), 32'd0);
        checkOutput("reset_mac_weight", 32'(mac_weight), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", out_data, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Test 1: back-to-back pairs
        clearGaps();
        px[0] = 8'd2; pw[0] = 8'd3; px[1] = 8'd4; pw[1] = 8'd5; px[2] = 8'd1; pw[2] = 8'd255;
        en_count = 0;
        applyStimulus(32'd100, 3, 0, 1'b0, -1);
        checkOutput("t1_sum", cap_out, 32'd381);
        checkOutput("t1_model", cap_model, 32'd381);
        checkOutput("t1_latency", 32'(valid_cyc - hs_cyc), 32'd2);
        checkOutput("t1_beats", 32'(en_count), 32'd3);

        // Test 2: zero-length job
        en_count = 0;
        applyStimulus(32'hFFFF_FFF0, 0, 0, 1'b0, -1);
        checkOutput("t2_sum", cap_out, t2_exp);
        checkOutput("t2_model", cap_model, t2_exp);
        checkOutput("t2_latency", 32'(valid_cyc - start_cyc), 32'd2);
        checkOutput("t2_beats", 32'(en_count), 32'd1);

        // Test 3: in_valid pattern 1,0,0,1,0,1
        gaps[0] = 0; gaps[1] = 2; gaps[2] = 1;
        en_count = 0;
        applyStimulus(32'd100, 3, 0, 1'b0, -1);
        checkOutput("t3_sum", cap_out, 32'd381);
        checkOutput("t3_beats", 32'(en_count), 32'd3);
        clearGaps();

        // Test 4: largest products
        for (int i = 0; i < 4; i++) begin px[i] = 8'd255; pw[i] = 8'd255; end
        applyStimulus(32'd0, 4, 0, 1'b0, -1);
        checkOutput("t4_sum", cap_out, 32'd260100);
        checkOutput("t4_model", cap_model, 32'd260100);

        // Test 5: DONE held with start pulsed, then an immediate next job
        px[0] = 8'd10; pw[0] = 8'd10; px[1] = 8'd1; pw[1] = 8'd1;
        applyStimulus(32'd5, 2, 5, 1'b1, -1);
        checkOutput("t5_sum", cap_out, 32'd106);
        px[0] = 8'd2; pw[0] = 8'd2;
        applyStimulus(32'd1, 1, 0, 1'b0, -1);
        checkOutput("t5_next_sum", cap_out, 32'd5);

        // Test 6: reset mid-job, then a fresh job
        for (int i = 0; i < 5; i++) begin px[i] = 8'd9; pw[i] = 8'd7; end
        applyStimulus(32'd50, 5, 0, 1'b0, 2);
        reset = 1'b1;
        #1;
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t6_mac_en", 32'(mac_en), 32'd0);
        checkOutput("t6_mac_x", 32'(mac_x), 32'd0);
        checkOutput("t6_mac_weight", 32'(mac_weight), 32'd0);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        px[0] = 8'd3; pw[0] = 8'd3;
        applyStimulus(32'd7, 1, 0, 1'b0, -1);
        checkOutput("t6_sum", cap_out, 32'd16);

        // Random jobs, including one maximum-length job
        for (int j = 0; j < 31; j++) begin
            int n;
            n = (j == 15) ? 255 : int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) begin
                px[i] = 8'($urandom);
                pw[i] = 8'($urandom);
                gaps[i] = ($urandom_range(0, 3) == 0 && j != 15) ? int'($urandom_range(1, 2)) : 0;
            end
            applyStimulus($urandom, n, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
            if (n > 0) clearGaps();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
